complement_arbiter: RTL and testbench

COMPLEMENT_ARBITER -- requirements
Module: complement_arbiter

---
 rtl/complement_pkg.sv | 13 +
 rtl/serial_complement_cell.sv | 27 ++
 rtl/complement_arbiter.sv | 120 ++++++++++++
 tb/tb_complement_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/complement_pkg.sv
// Shared types and default sizing for the serial two's-complement arbiter.
package complement_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREQ  = 4;

endpackage

// File: rtl/serial_complement_cell.sv
// Bit-serial two's-complement cell: passes bits through unchanged up to and
// including the first one, then inverts every later bit.
module serial_complement_cell (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  input  logic bit_i,
  output logic bit_o
);

  logic seen;

  assign bit_o = bit_i ^ seen;

  // Track whether a one has already gone past in the current word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      seen <= 1'b0;
    end else if (clr) begin
      seen <= 1'b0;
    end else if (en) begin
      seen <= seen | bit_i;
    end
  end

endmodule

// File: rtl/complement_arbiter.sv
// Round-robin arbiter sharing one bit-serial two's-complement unit among
// NREQ requesters.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | no owner; the first edge seeing any request grants a winner
//   SHIFT | one operand bit per edge, LSB first, WIDTH edges in total
//   DONE  | first cycle: settle; second cycle: done_o/result_o presented,
//         | then back to IDLE with grant released
module complement_arbiter
  import complement_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = DEF_NREQ
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_i,
  input  logic [NREQ*WIDTH-1:0] data_i,
  output logic [NREQ-1:0]       grant_o,
  output logic [NREQ-1:0]       done_o,
  output logic [WIDTH-1:0]      result_o,
  output logic                  busy_o
);

  localparam int CW = $clog2(WIDTH);
  localparam int IW = $clog2(NREQ);

  state_t           state;
  logic [WIDTH-1:0] r;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    last;
  logic [IW-1:0]    winner;

  logic             pick_valid;
  logic [IW-1:0]    pick_idx;
  logic [WIDTH-1:0] pick_data;

  logic             cell_clr;
  logic             cell_en;
  logic             cell_out;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    pick_data  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int j;
      j = (int'(last) + k) % NREQ;
      if (!pick_valid && req_i[j]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'(j);
        pick_data  = data_i[j*WIDTH +: WIDTH];
      end
    end
  end

  assign cell_clr = (state == IDLE) && pick_valid;
  assign cell_en  = (state == SHIFT);
  assign busy_o   = (state != IDLE);

  serial_complement_cell u_cell (
    .clk   (clk),
    .reset (reset),
    .clr   (cell_clr),
    .en    (cell_en),
    .bit_i (r[0]),
    .bit_o (cell_out)
  );

  // Controller, arbiter state and operand shift register.
  // done_o doubles as the phase flag inside DONE: low on the settle cycle,
  // high on the presentation cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      r        <= '0;
      cnt      <= '0;
      last     <= IW'(NREQ - 1);
      winner   <= '0;
      grant_o  <= '0;
      done_o   <= '0;
      result_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            r       <= pick_data;
            cnt     <= '0;
            winner  <= pick_idx;
            grant_o <= NREQ'(1) << pick_idx;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          r <= {cell_out, r[WIDTH-1:1]};
          if (cnt == CW'(WIDTH - 1)) begin
            state <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          if (done_o == '0) begin
            done_o   <= grant_o;
            result_o <= r;
            last     <= winner;
          end else begin
            done_o  <= '0;
            grant_o <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_complement_arbiter.sv
// Directed bench for complement_arbiter (WIDTH=8, NREQ=4).
module tb_complement_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_i;
  logic [31:0] data_i;
  logic [3:0]  grant_o;
  logic [3:0]  done_o;
  logic [7:0]  result_o;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  complement_arbiter #(.WIDTH(8), .NREQ(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req_i    (req_i),
    .data_i   (data_i),
    .grant_o  (grant_o),
    .done_o   (done_o),
    .result_o (result_o),
    .busy_o   (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic [7:0]  res;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one word from IDLE and follow it through edge 10.
  task automatic run_word(input string name, input logic [3:0] req, input logic [31:0] data,
                          input logic [3:0] exp_grant, input logic [7:0] exp_res);
    req_i  = req;
    data_i = data;
    step();
    chk({name, " grant"}, 32'(grant_o), 32'(exp_grant));
    chk({name, " busy"}, 32'(busy_o), 32'd1);
    data_i = ~data;
    for (int e = 1; e <= 8; e++) step();
    chk({name, " no early done"}, 32'(done_o), 32'd0);
    step();
    chk({name, " done"}, 32'(done_o), 32'(exp_grant));
    chk({name, " result"}, 32'(result_o), 32'(exp_res));
    req_i = '0;
    step();
    chk({name, " grant released"}, 32'(grant_o), 32'd0);
    chk({name, " done cleared"}, 32'(done_o), 32'd0);
    chk({name, " idle"}, 32'(busy_o), 32'd0);
    chk({name, " result held"}, 32'(result_o), 32'(exp_res));
  endtask

  // Wait for the next done pulse, checking its cycle distance and contents.
  task automatic wait_done(input string name, input logic [3:0] exp_done,
                           input logic [7:0] exp_res, input int exp_n);
    int n;
    n = 0;
    while (n <= 40) begin
      n++;
      step();
      if (done_o != '0) break;
    end
    chk({name, " latency"}, 32'(n), 32'(exp_n));
    chk({name, " done"}, 32'(done_o), 32'(exp_done));
    chk({name, " result"}, 32'(result_o), 32'(exp_res));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_i = '0;
    repeat (2) step();
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;

    tbl[0] = '{req: 4'b0010, data: 32'h00_00_05_00, grant: 4'b0010, res: 8'hFB};
    tbl[1] = '{req: 4'b0001, data: 32'h11_22_33_00, grant: 4'b0001, res: 8'h00};
    tbl[2] = '{req: 4'b0100, data: 32'h00_80_00_00, grant: 4'b0100, res: 8'h80};
    tbl[3] = '{req: 4'b1000, data: 32'hFF_00_00_00, grant: 4'b1000, res: 8'h01};
    tbl[4] = '{req: 4'b0001, data: 32'h00_00_00_01, grant: 4'b0001, res: 8'hFF};
    tbl[5] = '{req: 4'b0010, data: 32'h00_00_3C_00, grant: 4'b0010, res: 8'hC4};
    tbl[6] = '{req: 4'b0101, data: 32'h00_7F_00_11, grant: 4'b0100, res: 8'h81};
    tbl[7] = '{req: 4'b1001, data: 32'h10_00_00_22, grant: 4'b1000, res: 8'hF0};
    tbl[8] = '{req: 4'b0011, data: 32'h00_00_44_AA, grant: 4'b0001, res: 8'h56};

    reset  = 1'b0;
    req_i  = '0;
    data_i = '0;
    repeat (3) step();
    chk("reset grant", 32'(grant_o), 32'd0);
    chk("reset done", 32'(done_o), 32'd0);
    chk("reset busy", 32'(busy_o), 32'd0);
    chk("reset result", 32'(result_o), 32'd0);
    reset = 1'b1;
    step();
    chk("idle without req", 32'(busy_o), 32'd0);

    for (int i = 0; i < 9; i++) begin
      run_word($sformatf("vec%0d", i), tbl[i].req, tbl[i].data, tbl[i].grant, tbl[i].res);
    end

    // All four requesting continuously from reset.
    do_reset();
    req_i  = 4'b1111;
    data_i = 32'hFE_00_80_05;
    wait_done("rr0", 4'b0001, 8'hFB, 10);
    wait_done("rr1", 4'b0010, 8'h80, 11);
    wait_done("rr2", 4'b0100, 8'h00, 11);
    wait_done("rr3", 4'b1000, 8'h02, 11);
    wait_done("rr4", 4'b0001, 8'hFB, 11);

    // Only requesters 0 and 3 active: they alternate.
    do_reset();
    req_i  = 4'b1001;
    data_i = 32'h03_FF_FF_01;
    wait_done("alt0", 4'b0001, 8'hFF, 10);
    wait_done("alt1", 4'b1000, 8'hFD, 11);
    wait_done("alt2", 4'b0001, 8'hFF, 11);
    wait_done("alt3", 4'b1000, 8'hFD, 11);

    // Reset in the middle of a shift discards the word and the seen flag.
    do_reset();
    req_i  = 4'b0100;
    data_i = 32'h00_0F_00_00;
    step();
    chk("abort grant", 32'(grant_o), 32'b0100);
    repeat (4) step();
    reset = 1'b0;
    req_i = '0;
    step();
    chk("abort busy", 32'(busy_o), 32'd0);
    chk("abort grant cleared", 32'(grant_o), 32'd0);
    reset = 1'b1;
    bad = 0;
    for (int e = 0; e < 12; e++) begin
      step();
      if (done_o != '0) bad++;
    end
    chk("abort no done", 32'(bad), 32'd0);
    run_word("after abort", 4'b0100, 32'h00_02_00_00, 4'b0100, 8'hFE);

    // Owner drops its request mid-shift; others must wait.
    do_reset();
    req_i  = 4'b0010;
    data_i = 32'h77_66_33_55;
    step();
    chk("drop grant", 32'(grant_o), 32'b0010);
    repeat (2) step();
    req_i = 4'b0101;
    bad = 0;
    for (int e = 3; e <= 8; e++) begin
      step();
      if (grant_o != 4'b0010 || done_o != '0) bad++;
    end
    chk("drop grant held", 32'(bad), 32'd0);
    step();
    chk("drop done", 32'(done_o), 32'b0010);
    chk("drop result", 32'(result_o), 32'hCD);
    step();
    chk("drop released", 32'(grant_o), 32'd0);
    step();
    chk("drop next grant", 32'(grant_o), 32'b0100);
    do_reset();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
